tnoc_flit_vc_sender: RTL and testbench
======================================

// Module: tnoc_flit_vc_sender
// PURPOSE
//  Transmit side of the flit interface: merges CHANNELS per-VC local flit streams onto one
//  shared internal flit lane (one flit bus, one-hot per-VC valid) feeding a downstream flit FIFO.
//  Packet-atomic round-robin arbitration, gated by downstream per-VC vc_available/ready.
//  Sits at a router/NIC output, upstream of the internal-port flit FIFO.
// PARAMETERS
//  CHANNELS    2   number of virtual channels (>=1)
//  FLIT_WIDTH  64  flit payload width in bits
// PORTS
//  clk               in   1                    clock
//  rst               in   1                    synchronous active-high reset
//  i_clear           in   1                    synchronous flush (same effect as rst)
//  i_valid           in   CHANNELS             per-VC source flit valid
//  o_ready           out  CHANNELS             per-VC source flit accept
//  i_flit            in   CHANNELS*FLIT_WIDTH  per-VC flit, VC v at [v*FLIT_WIDTH +: FLIT_WIDTH]
//  i_head            in   CHANNELS             flit is head of packet
//  i_tail            in   CHANNELS             flit is tail of packet (head&tail = 1-flit packet)
//  o_valid           out  CHANNELS             downstream valid, one-hot (VC of o_flit)
//  i_ready           in   CHANNELS             downstream per-VC ready
//  i_vc_available    in   CHANNELS             downstream per-VC room for a new packet
//  o_flit            out  FLIT_WIDTH           downstream flit
//  o_busy            out  1                    packet in progress or output register occupied
// BEHAVIOUR
//  Reset/clear: o_valid=0, o_flit=0, o_busy=0, state=IDLE, rr pointer=0; o_ready=0 while rst/i_clear high.
//  Transfer in: i_valid[v]&o_ready[v]. Transfer out: o_valid[v]&i_ready[v].
//  Output register (1 entry): can load when empty or when draining this cycle (flow-through).
//   o_ready[v] = (v==grant) & load_ok & state-permits; at most one o_ready bit high.
//  Latency: flit accepted in cycle N drives o_valid/o_flit in cycle N+1; 1 flit/cycle sustained.
//  FSM: IDLE -> arbitrate; LOCKED -> stay on granted VC.
//   IDLE: req[v] = i_valid[v] & i_head[v] & i_vc_available[v]; round-robin pick starting at
//    pointer; head flit accepted same cycle if load_ok. Accepted head&~tail -> LOCKED(grant=v);
//    head&tail -> stay IDLE. Pointer <= v+1 (mod CHANNELS) on every accepted tail.
//   LOCKED: only granted VC accepted; i_vc_available ignored; tail accepted -> IDLE.
//  No bubble between packets: tail at N, next head may be accepted at N+1.
//  Non-head flit on an idle VC is never accepted (o_ready stays 0; protocol error, no recovery).
//  Downstream stall (i_ready[v]=0): o_valid/o_flit held stable; o_ready deasserts.
//  i_vc_available dropping mid-packet does not stall the packet; only ready does.
//  o_valid must never change VC while high without a transfer.
//  rst or i_clear mid-packet: output flit discarded, FSM IDLE, pointer 0 next cycle.
//  CHANNELS==1: arbiter degenerates; same FSM and gating.
// TESTING
//  1. Reset: rst=1 3 cycles with i_valid=2'b11 -> o_valid=0,o_ready=0,o_busy=0 throughout.
//  2. VC0 4-flit pkt (0xA0..0xA3), ready=1 -> o_valid=2'b01, flits out cycles N+1..N+4, no gaps.
//  3. VC0,VC1 both 2-flit pkts, heads same cycle, ptr=0 -> VC0 pkt fully, then VC1, never interleaved.
//  4. i_vc_available=2'b10, both heads valid -> VC1 sent; VC0 waits until its vc_available=1.
//  5. i_ready[0]=0 for 5 cycles mid-pkt -> o_flit held at 0xA1, o_ready=0; resumes, no loss/dup.
//  6. i_clear pulse after head of 3-flit pkt -> o_valid=0 next cycle, IDLE; fresh pkt sent normally.

Source files
------------

// File: rtl/tnoc_flit_vc_sender.sv
// tnoc_flit_vc_sender
// Merges CHANNELS per-VC flit streams onto one shared flit lane with a
// one-hot per-VC valid. Arbitration is packet-atomic round robin among VCs
// presenting a head flit with downstream room; once a multi-flit packet
// starts, only its VC is served until the tail goes out. A single output
// register gives one-cycle latency and sustains one flit per cycle by
// reloading in the same cycle it drains.
module tnoc_flit_vc_sender #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clear,
  input  logic [CHANNELS-1:0]            i_valid,
  output logic [CHANNELS-1:0]            o_ready,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit,
  input  logic [CHANNELS-1:0]            i_head,
  input  logic [CHANNELS-1:0]            i_tail,
  output logic [CHANNELS-1:0]            o_valid,
  input  logic [CHANNELS-1:0]            i_ready,
  input  logic [CHANNELS-1:0]            i_vc_available,
  output logic [FLIT_WIDTH-1:0]          o_flit,
  output logic                           o_busy
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      ptr_q,   ptr_d;
  logic [CHANNELS-1:0]   valid_q, valid_d;
  logic [FLIT_WIDTH-1:0] flit_q,  flit_d;

  logic                  flush;
  logic                  drain;
  logic                  load_ok;
  logic [CHANNELS-1:0]   req;
  logic [IDX_W-1:0]      pick;
  logic                  pick_found;
  logic [IDX_W-1:0]      sel;
  logic                  accept;
  logic                  sel_tail;
  logic [FLIT_WIDTH-1:0] sel_flit;

  // A clear behaves exactly like reset, including blocking new accepts.
  assign flush   = rst | i_clear;
  assign drain   = |(valid_q & i_ready);
  // The output register may take a new flit when empty or emptying now.
  assign load_ok = ~(|valid_q) | drain;
  // Only a head flit whose downstream VC has room may open a packet.
  assign req     = i_valid & i_head & i_vc_available;

  // Round-robin search over head requests, starting at the pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a variable unassigned and infers a latch.
    logic [IDX_W-1:0] idx;
    pick       = '0;
    pick_found = 1'b0;
    idx        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = IDX_W'((int'(ptr_q) + i) % CHANNELS);
      if (!pick_found && req[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  // Source-side handshake: at most one VC is offered ready at a time.
  always_comb begin
    o_ready = '0;
    if (!flush && load_ok) begin
      if (state_q == ST_LOCKED) begin
        o_ready[grant_q] = 1'b1;
      end else if (pick_found) begin
        o_ready[pick] = 1'b1;
      end
    end
  end

  assign sel      = (state_q == ST_LOCKED) ? grant_q : pick;
  assign accept   = |(i_valid & o_ready);
  assign sel_tail = i_tail[sel];
  assign sel_flit = i_flit[int'(sel)*FLIT_WIDTH +: FLIT_WIDTH];

  // Next state for the packet FSM, round-robin pointer and output register.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    flit_d  = flit_q;
    if (drain) begin
      valid_d = '0;
    end
    if (accept) begin
      valid_d = CHANNELS'(1) << sel;
      flit_d  = sel_flit;
      if (sel_tail) begin
        state_d = ST_IDLE;
        ptr_d   = (sel == IDX_W'(CHANNELS - 1)) ? '0 : sel + IDX_W'(1);
      end else begin
        state_d = ST_LOCKED;
        grant_d = sel;
      end
    end
  end

  // State registers; a flush discards the held flit and restarts arbitration.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (flush) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      valid_q <= '0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      flit_q  <= flit_d;
    end
  end

  assign o_valid = valid_q;
  assign o_flit  = flit_q;
  assign o_busy  = (state_q == ST_LOCKED) | (|valid_q);

endmodule

// File: tb/tb_tnoc_flit_vc_sender.sv
// Testbench for tnoc_flit_vc_sender (CHANNELS=2, FLIT_WIDTH=64).
// Per-VC source queues feed the DUT; each scenario pushes the flits it
// expects on the output lane, in the expected order, to a scoreboard that a
// background monitor pops on every downstream transfer.
module tb_tnoc_flit_vc_sender;

  localparam int CH = 2;
  localparam int FW = 64;

  typedef struct {
    logic          head;
    logic          tail;
    logic [FW-1:0] data;
  } src_t;

  typedef struct {
    int            vc;
    logic [FW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_clear;
  logic [CH-1:0]    i_valid;
  logic [CH-1:0]    o_ready;
  logic [CH*FW-1:0] i_flit;
  logic [CH-1:0]    i_head;
  logic [CH-1:0]    i_tail;
  logic [CH-1:0]    o_valid;
  logic [CH-1:0]    i_ready;
  logic [CH-1:0]    i_vc_available;
  logic [FW-1:0]    o_flit;
  logic             o_busy;

  src_t src_q[CH][$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  tnoc_flit_vc_sender #(
    .CHANNELS  (CH),
    .FLIT_WIDTH(FW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (i_clear),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_flit        (i_flit),
    .i_head        (i_head),
    .i_tail        (i_tail),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .i_vc_available(i_vc_available),
    .o_flit        (o_flit),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  task automatic push_src(input int vc, input logic [FW-1:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      src_t s;
      s.head = (i == 0);
      s.tail = (i == len - 1);
      s.data = base + FW'(i);
      src_q[vc].push_back(s);
    end
  endtask

  task automatic push_exp(input int vc, input logic [FW-1:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.vc   = vc;
      e.data = base + FW'(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
            o_valid != '0 || o_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s_drain: timed out, pending expected=%0d src0=%0d src1=%0d busy=%b",
               name, exp_q.size(), src_q[0].size(), src_q[1].size(), o_busy);
      exp_q.delete();
      src_q[0].delete();
      src_q[1].delete();
    end
    step();
  endtask

  // Reset held with both VCs presenting 1-flit packets; nothing may move.
  task automatic test_reset();
    push_src(0, 64'h11, 1);
    push_src(1, 64'h22, 1);
    push_exp(0, 64'h11, 1);
    push_exp(1, 64'h22, 1);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (o_valid !== 2'b00 || o_ready !== 2'b00 || o_busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: o_valid=%b o_ready=%b o_busy=%b, want 00 00 0",
                 o_valid, o_ready, o_busy);
      end
    end
    step();
    rst = 1'b0;
    wait_idle("reset_release");
  endtask

  // Both VCs start a 2-flit packet in the same cycle with the pointer at 0.
  task automatic test_two_pkts();
    push_src(0, 64'hB0, 2);
    push_src(1, 64'hC0, 2);
    push_exp(0, 64'hB0, 2);
    push_exp(1, 64'hC0, 2);
    wait_idle("two_pkts");
  endtask

  // 4-flit packet on VC0: one-cycle latency and no gaps between flits.
  task automatic test_single_pkt();
    int n = 0;
    push_src(0, 64'hA0, 4);
    push_exp(0, 64'hA0, 4);
    do begin
      @(negedge clk);
      n++;
    end while (!(i_valid[0] && o_ready[0] && i_head[0]) && n < 50);
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL single_head_accept: head never accepted, o_ready=%b", o_ready);
    end else begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        total++;
        if (o_valid !== 2'b01 || o_flit !== 64'hA0 + FW'(i)) begin
          bad++;
          $display("FAIL single_stream[%0d]: o_valid=%b o_flit=%h, want 01 %h",
                   i, o_valid, o_flit, 64'hA0 + FW'(i));
        end
      end
    end
    wait_idle("single_pkt");
  endtask

  // VC0 has no downstream room: VC1 goes first, VC0 waits for its room.
  task automatic test_vc_available();
    i_vc_available = 2'b10;
    push_src(0, 64'hD0, 2);
    push_src(1, 64'hE0, 2);
    push_exp(1, 64'hE0, 2);
    push_exp(0, 64'hD0, 2);
    repeat (10) @(negedge clk);
    total++;
    if (src_q[0].size() !== 2 || exp_q.size() !== 2 || o_ready !== 2'b00 || o_valid !== 2'b00) begin
      bad++;
      $display("FAIL vc_avail_block: vc0 left=%0d expected left=%0d o_ready=%b o_valid=%b, want 2 2 00 00",
               src_q[0].size(), exp_q.size(), o_ready, o_valid);
    end
    step();
    i_vc_available = 2'b11;
    wait_idle("vc_available");
  endtask

  // Downstream stall on VC0 while flit A1 sits in the output register.
  task automatic test_stall();
    int n = 0;
    push_src(0, 64'hA0, 4);
    push_exp(0, 64'hA0, 4);
    do begin
      @(negedge clk);
      n++;
    end while (!(o_valid[0] && o_flit == 64'hA0) && n < 50);
    step();
    i_ready = 2'b10;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (o_valid !== 2'b01 || o_flit !== 64'hA1 || o_ready !== 2'b00) begin
        bad++;
        $display("FAIL stall_hold: o_valid=%b o_flit=%h o_ready=%b, want 01 a1 00",
                 o_valid, o_flit, o_ready);
      end
    end
    step();
    i_ready = 2'b11;
    wait_idle("stall");
  endtask

  // Clear after the head of a 3-flit packet; a fresh packet on VC1 follows.
  task automatic test_clear();
    int n = 0;
    i_ready = 2'b00;
    push_src(0, 64'hF0, 3);
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid[0] && n < 50);
    total++;
    if (o_valid !== 2'b01 || o_flit !== 64'hF0 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL clear_pre: o_valid=%b o_flit=%h o_busy=%b, want 01 f0 1", o_valid, o_flit, o_busy);
    end
    step();
    i_clear = 1'b1;
    src_q[0].delete();
    i_valid = 2'b00;
    i_head  = 2'b00;
    i_tail  = 2'b00;
    @(negedge clk);
    total++;
    if (o_ready !== 2'b00) begin
      bad++;
      $display("FAIL clear_ready: o_ready=%b, want 00", o_ready);
    end
    step();
    i_clear = 1'b0;
    @(negedge clk);
    total++;
    if (o_valid !== 2'b00 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_post: o_valid=%b o_busy=%b, want 00 0", o_valid, o_busy);
    end
    step();
    i_ready = 2'b11;
    push_src(1, 64'h90, 3);
    push_exp(1, 64'h90, 3);
    wait_idle("clear");
  endtask

  // 1-flit packet then 2-flit packet on VC1: three flits on consecutive cycles.
  task automatic test_back_to_back();
    int   n = 0;
    logic [FW-1:0] want[3];
    want[0] = 64'h50;
    want[1] = 64'h60;
    want[2] = 64'h61;
    push_src(1, 64'h50, 1);
    push_src(1, 64'h60, 2);
    push_exp(1, 64'h50, 1);
    push_exp(1, 64'h60, 2);
    do begin
      @(negedge clk);
      n++;
    end while (o_valid == 2'b00 && n < 50);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (o_valid !== 2'b10 || o_flit !== want[i]) begin
        bad++;
        $display("FAIL back_to_back[%0d]: o_valid=%b o_flit=%h, want 10 %h", i, o_valid, o_flit, want[i]);
      end
    end
    wait_idle("back_to_back");
  endtask

  initial begin
    rst            = 1'b1;
    i_clear        = 1'b0;
    i_valid        = '0;
    i_flit         = '0;
    i_head         = '0;
    i_tail         = '0;
    i_ready        = 2'b11;
    i_vc_available = 2'b11;

    fork
      // Source driver: retire accepted flits, present the next queue entry.
      begin
        logic [CH-1:0] acc;
        forever begin
          @(negedge clk);
          acc = i_valid & o_ready;
          @(posedge clk);
          #1;
          for (int v = 0; v < CH; v++) begin
            if (acc[v] && src_q[v].size() > 0) void'(src_q[v].pop_front());
            if (src_q[v].size() > 0) begin
              i_valid[v]            = 1'b1;
              i_head[v]             = src_q[v][0].head;
              i_tail[v]             = src_q[v][0].tail;
              i_flit[v*FW +: FW]    = src_q[v][0].data;
            end else begin
              i_valid[v] = 1'b0;
              i_head[v]  = 1'b0;
              i_tail[v]  = 1'b0;
            end
          end
        end
      end
      // Output monitor: scoreboard on transfers, one-hot and hold checks.
      begin
        logic [CH-1:0] prev_v   = '0;
        logic [FW-1:0] prev_f   = '0;
        logic          prev_x   = 1'b0;
        logic          prev_clr = 1'b1;
        logic [CH-1:0] xfer;
        logic [CH-1:0] ev;
        exp_t          e;
        forever begin
          @(negedge clk);
          xfer = o_valid & i_ready;
          total++;
          if (!$onehot0(o_ready) || !$onehot0(o_valid)) begin
            bad++;
            $display("FAIL onehot: o_ready=%b o_valid=%b, want at most one bit each", o_ready, o_valid);
          end
          if (prev_v != '0 && !prev_x && !prev_clr) begin
            total++;
            if (o_valid !== prev_v || o_flit !== prev_f) begin
              bad++;
              $display("FAIL hold: o_valid=%b o_flit=%h, want %b %h", o_valid, o_flit, prev_v, prev_f);
            end
          end
          if (xfer != '0) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_flit: o_valid=%b o_flit=%h, want no transfer", o_valid, o_flit);
            end else begin
              e  = exp_q.pop_front();
              ev = 2'b01 << e.vc;
              if (o_valid !== ev || o_flit !== e.data) begin
                bad++;
                $display("FAIL scoreboard: o_valid=%b o_flit=%h, want %b %h", o_valid, o_flit, ev, e.data);
              end
            end
          end
          prev_v   = o_valid;
          prev_f   = o_flit;
          prev_x   = (xfer != '0);
          prev_clr = rst | i_clear;
        end
      end
    join_none

    test_reset();
    test_two_pkts();
    test_single_pkt();
    test_vc_available();
    test_stall();
    test_clear();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
